// File: rtl/eprom_bus_pkg.sv
// Shared constants and state encoding for the boot EPROM bus controller.
// Optional read cache is enabled by defining EPROM_BUS_CTRL_CACHE_EN.
`timescale 1ns/1ps
package eprom_bus_pkg;

  localparam int unsigned ADDR_W_DEF      = 20;
  localparam int unsigned DATA_W          = 8;
  localparam int unsigned CNT_W           = 4;

  localparam int unsigned WAIT_STATES_DEF = 2;
  localparam int unsigned WAIT_STATES_MIN = 1;
  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned RECOVERY_DEF    = 1;
  localparam int unsigned RECOVERY_MIN    = 0;
  localparam int unsigned RECOVERY_MAX    = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_READ    = 3'd2,
    ST_LATCH   = 3'd3,
    ST_RECOVER = 3'd4,
    ST_HIT     = 3'd5
  } state_e;

endpackage

// File: rtl/eprom_rr_arbiter.sv
// Two-way round-robin arbiter: the port that did not win last time wins a tie.
`timescale 1ns/1ps
module eprom_rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_sel
);

  // Grant selection; a lone requester always wins.
  always_comb begin
    grant_valid = req0 | req1;
    grant_sel   = 1'b0;
    if (req0 && req1) begin
      grant_sel = ~last_grant;
    end else if (req1) begin
      grant_sel = 1'b1;
    end
  end

endmodule

// File: rtl/eprom_bus_ctrl.sv
// Boot EPROM read sequencer shared by two requesters (0 = fetch, 1 = loader).
// Define EPROM_BUS_CTRL_CACHE_EN to add a one-entry read cache that bypasses the EPROM on a hit.
`timescale 1ns/1ps
module eprom_bus_ctrl
  import eprom_bus_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF,
  parameter int unsigned RECOVERY    = RECOVERY_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic              _cs,
  output logic              _oe,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);

  state_e            state;
  logic              sel;
  logic              last_grant;
  logic [CNT_W-1:0]  cnt;
  logic              grant_valid;
  logic              grant_sel;
  logic [ADDR_W-1:0] grant_addr;

  eprom_rr_arbiter u_arb (
    .req0        (req0),
    .req1        (req1),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel)
  );

  assign grant_addr = grant_sel ? addr1 : addr0;

`ifdef EPROM_BUS_CTRL_CACHE_EN
  logic              cache_valid;
  logic [ADDR_W-1:0] cache_tag;
  logic [DATA_W-1:0] cache_byte;
  logic              cache_hit;

  assign cache_hit = cache_valid && (cache_tag == grant_addr);

  // Single-entry cache, filled with every byte sampled from the EPROM.
  always_ff @(posedge clk) begin
    if (reset) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_byte  <= '0;
    end else if (state == ST_READ && cnt == CNT_W'(WAIT_STATES - 1)) begin
      cache_valid <= 1'b1;
      cache_tag   <= rom_addr;
      cache_byte  <= rom_data;
    end
  end
`endif

  // Access sequencer: arbitration, strobe timing, data return and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
      _cs        <= 1'b1;
      _oe        <= 1'b1;
      rom_addr   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      busy       <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            last_grant <= grant_sel;
            sel        <= grant_sel;
            busy       <= 1'b1;
`ifdef EPROM_BUS_CTRL_CACHE_EN
            if (cache_hit) begin
              state <= ST_HIT;
              if (grant_sel) begin
                ack1   <= 1'b1;
                rdata1 <= cache_byte;
              end else begin
                ack0   <= 1'b1;
                rdata0 <= cache_byte;
              end
            end else begin
              state    <= ST_SETUP;
              rom_addr <= grant_addr;
              _cs      <= 1'b0;
            end
`else
            state    <= ST_SETUP;
            rom_addr <= grant_addr;
            _cs      <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          state <= ST_READ;
          _oe   <= 1'b0;
          cnt   <= '0;
        end
        ST_READ: begin
          if (cnt == CNT_W'(WAIT_STATES - 1)) begin
            state <= ST_LATCH;
            _cs   <= 1'b1;
            _oe   <= 1'b1;
            if (sel) begin
              ack1   <= 1'b1;
              rdata1 <= rom_data;
            end else begin
              ack0   <= 1'b1;
              rdata0 <= rom_data;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_LATCH: begin
          cnt <= '0;
          if (RECOVERY != 0) begin
            state <= ST_RECOVER;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_RECOVER: begin
          if (cnt == CNT_W'(RECOVERY - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_HIT: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          _cs   <= 1'b1;
          _oe   <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eprom_bus_ctrl.sv
// Scoreboard bench for eprom_bus_ctrl; builds with or without EPROM_BUS_CTRL_CACHE_EN.
`timescale 1ns/1ps
module tb_eprom_bus_ctrl;

`ifdef EPROM_BUS_CTRL_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif
  localparam int WS    = 2;
  localparam int RC    = 1;
  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [19:0] addr0, addr1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic        cs_n, oe_n;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        busy;

  logic [7:0]  rom_mem [256];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  int          ack_order[$];
  int          cs_low_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eprom_bus_ctrl dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .addr1(addr1), .ack1(ack1), .rdata1(rdata1),
    ._cs(cs_n), ._oe(oe_n), .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy)
  );

  // Behavioural EPROM: drives the bus only while selected and output-enabled.
  assign rom_data = (!cs_n && !oe_n) ? rom_mem[rom_addr[7:0]] : 8'h00;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: no response within %0d cycles", name, BOUND);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One read on port p; expected byte queued at issue. keep=1 leaves req high for back-to-back.
  // lat = cycles from the req-seen cycle (or the previous ack) to this ack.
  task automatic issue(input int p, input logic [19:0] a, input bit keep, output int lat);
    int c0;
    int n;
    if (p == 0) begin addr0 = a; q0.push_back(rom_mem[a[7:0]]); end
    else        begin addr1 = a; q1.push_back(rom_mem[a[7:0]]); end
    if ((p == 0 && !req0) || (p == 1 && !req1)) begin
      @(posedge clk); #1;
      if (p == 0) req0 = 1'b1; else req1 = 1'b1;
    end
    c0 = cyc;
    n  = 0;
    do begin @(negedge clk); n++; end
    while (!((p == 0) ? ack0 : ack1) && n < BOUND);
    if (n >= BOUND) timeout($sformatf("ack%0d", p));
    lat = cyc - c0;
    if (!keep) begin
      @(posedge clk); #1;
      if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  // Monitor: scoreboard pops on ack plus bus-protocol checks every cycle.
  initial begin : monitor
    int          oe_run;
    bit          prev_cs_low;
    logic [19:0] prev_addr;
    oe_run = 0; prev_cs_low = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (ack0 && ack1) chk("ack_exclusive", 1, 0);
      if (ack0) begin
        ack_order.push_back(0);
        if (q0.size() == 0) chk("unexpected_ack0", 1, 0);
        else chk("rdata0", rdata0, q0.pop_front());
      end
      if (ack1) begin
        ack_order.push_back(1);
        if (q1.size() == 0) chk("unexpected_ack1", 1, 0);
        else chk("rdata1", rdata1, q1.pop_front());
      end
      if (!cs_n) cs_low_cnt++;
      if (reset) begin
        oe_run = 0;
        prev_cs_low = 1'b0;
      end else begin
        if (!oe_n && cs_n) chk("oe_without_cs", 1, 0);
        if (!oe_n) oe_run++;
        else if (oe_run != 0) begin
          chk("oe_low_cycles", oe_run, WS);
          oe_run = 0;
        end
        if (!cs_n && prev_cs_low && rom_addr != prev_addr) chk("rom_addr_stable", rom_addr, prev_addr);
        prev_cs_low = !cs_n;
        prev_addr   = rom_addr;
      end
    end
  end

  // Alternate-parameter instances: latency and back-to-back period.
  for (genvar g = 0; g < 2; g++) begin : gen_p
    localparam int PWS = (g == 0) ? 1 : 15;
    localparam int PRC = (g == 0) ? 0 : 1;
    logic        p_reset, p_req, p_ack, p_ack1, p_cs, p_oe, p_busy, p_done;
    logic [19:0] p_addr, p_rom_addr;
    logic [19:0] p_addr1;
    logic        p_req1;
    logic [7:0]  p_rdata, p_rdata1, p_rom_data;

    eprom_bus_ctrl #(.WAIT_STATES(PWS), .RECOVERY(PRC)) dut_p (
      .clk(clk), .reset(p_reset),
      .req0(p_req), .addr0(p_addr), .ack0(p_ack), .rdata0(p_rdata),
      .req1(p_req1), .addr1(p_addr1), .ack1(p_ack1), .rdata1(p_rdata1),
      ._cs(p_cs), ._oe(p_oe), .rom_addr(p_rom_addr), .rom_data(p_rom_data), .busy(p_busy)
    );
    assign p_rom_data = (!p_cs && !p_oe) ? rom_mem[p_rom_addr[7:0]] : 8'h00;

    initial begin : pchk
      int          c0;
      int          n;
      logic [19:0] a;
      p_done = 1'b0; p_reset = 1'b1; p_req = 1'b0; p_req1 = 1'b0;
      p_addr = '0; p_addr1 = '0;
      repeat (3) @(posedge clk);
      #1 p_reset = 1'b0;
      @(posedge clk); #1;
      a = 20'(g * 16 + 1);
      p_addr = a; p_req = 1'b1; c0 = cyc;
      for (int k = 0; k < 2; k++) begin
        n = 0;
        do begin @(negedge clk); n++; end while (!p_ack && n < BOUND);
        if (n >= BOUND) timeout("param_ack");
        chk((k == 0) ? "param_latency" : "param_period", cyc - c0,
            (k == 0) ? PWS + 2 : PWS + 3 + PRC);
        chk("param_rdata", p_rdata, rom_mem[a[7:0]]);
        chk("param_ack1_idle", p_ack1, 0);
        c0 = cyc;
        a = a + 20'd1;
        p_addr = a;
      end
      @(posedge clk); #1 p_req = 1'b0;
      p_done = 1'b1;
    end
  end

  initial begin : main
    int          l0, l1, t, n;
    int          c_before;
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'hA5;
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cs", cs_n, 1);        chk("rst_oe", oe_n, 1);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ack0", ack0, 0);      chk("rst_ack1", ack1, 0);
    chk("rst_rdata0", rdata0, 0);  chk("rst_rdata1", rdata1, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single read.
    issue(0, 20'h00010, 1'b0, l0);
    chk("single_latency", l0, WS + 2);
    chk("single_rdata", rdata0, 8'hB5);

    // Contention after reset, then held requests alternate.
    apply_reset();
    ack_order.delete();
    fork
      begin issue(0, 20'd3, 1'b1, l0); issue(0, 20'd5, 1'b1, t); issue(0, 20'd7, 1'b0, t); end
      begin issue(1, 20'd4, 1'b1, l1); issue(1, 20'd6, 1'b1, t); issue(1, 20'd8, 1'b0, t); end
    join
    chk("contend_lat0", l0, WS + 2);
    chk("contend_lat1", l1, 2 * WS + 5 + RC);
    chk("rr_count", ack_order.size(), 6);
    for (int i = 0; i < ack_order.size(); i++) chk($sformatf("rr_order%0d", i), ack_order[i], i % 2);

    // Back-to-back on port 1 with stepping address.
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      issue(1, 20'(i), (i < 7), t);
      chk($sformatf("b2b_%0d", i), t, (i == 0) ? WS + 2 : WS + 3 + RC);
    end

    // Reset during READ aborts the access without an ack.
    apply_reset();
    @(posedge clk); #1 addr0 = 20'h00055; req0 = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (oe_n && n < BOUND);
    if (n >= BOUND) timeout("oe_low");
    #1 reset = 1'b1; req0 = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs_n, 1); chk("abort_oe", oe_n, 1);
    chk("abort_busy", busy, 0); chk("abort_ack0", ack0, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    issue(0, 20'h00056, 1'b0, l0);
    chk("after_abort_latency", l0, WS + 2);

    // Repeated address: cache hit when enabled, full cycle otherwise.
    apply_reset();
    issue(0, 20'h00020, 1'b0, l0);
    chk("cache_first", l0, WS + 2);
    c_before = cs_low_cnt;
    issue(0, 20'h00020, 1'b0, l0);
    chk("cache_second", l0, CACHE ? 1 : WS + 2);
    chk("cache_cs_low", cs_low_cnt - c_before, CACHE ? 0 : WS + 1);
    issue(0, 20'h00021, 1'b0, l0);
    chk("cache_miss", l0, WS + 2);

    // Random traffic on both ports.
    fork
      begin
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          issue(0, 20'($urandom_range(0, 15)), 1'b0, l0);
          checks++;
          if (l0 < 1 || l0 > 2 * WS + 5 + RC) begin
            errors++;
            $display("FAIL rand_lat0: got %0d, allowed 1..%0d", l0, 2 * WS + 5 + RC);
          end
        end
      end
      begin
        for (int k = 0; k < 15; k++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          issue(1, 20'($urandom_range(0, 15)), 1'b0, l1);
          checks++;
          if (l1 < 1 || l1 > 2 * WS + 5 + RC) begin
            errors++;
            $display("FAIL rand_lat1: got %0d, allowed 1..%0d", l1, 2 * WS + 5 + RC);
          end
        end
      end
    join

    n = 0;
    while (!(gen_p[0].p_done && gen_p[1].p_done) && n < BOUND) begin @(posedge clk); n++; end
    if (n >= BOUND) timeout("param_done");
    repeat (10) @(posedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
